// File: rtl/burst_scheduler.sv
// Slot-aligned burst scheduler: arbitrates two burst requesters and fires the burst controller on its target timeslot.
// Define BURST_SCHED_STATS_EN to add saturating fired/missed pulse counters.
module burst_scheduler #(
    parameter int SLOT_LEN      = 625,
    parameter int NUM_SLOTS     = 8,
    parameter int TIMEOUT_SLOTS = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sample_strobe,
    input  logic        req_a,
    input  logic        req_b,
    input  logic [2:0]  req_a_slot,
    input  logic [2:0]  req_b_slot,
    output logic        grant_a,
    output logic        grant_b,
    input  logic        is_armed,
    input  logic        iq_valid,
    output logic        fire_burst,
    output logic [2:0]  slot_index,
    output logic        missed,
    output logic        overrun,
    output logic        busy,
    output logic [15:0] fired_count,
    output logic [15:0] missed_count
);

    localparam int CW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_SLOTS + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(SLOT_LEN - 1);
    localparam logic [2:0]    SLOT_LAST  = 3'(NUM_SLOTS - 1);
    localparam logic [TW-1:0] BOUND_LAST = TW'(TIMEOUT_SLOTS - 1);

    typedef enum logic [1:0] {IDLE, PENDING, ACTIVE} state_t;

    state_t        state, state_next;
    logic [CW-1:0] sample_cnt;
    logic [2:0]    target_slot, target_next;
    logic          prefer_b, prefer_b_next;
    logic          iq_seen, iq_seen_next;
    logic [TW-1:0] bound_cnt, bound_next;
    logic          fire_next, missed_next, overrun_next;
    logic          boundary;
    logic [2:0]    slot_inc;

    assign boundary = sample_strobe && (sample_cnt == CNT_LAST);
    assign slot_inc = (slot_index == SLOT_LAST) ? '0 : slot_index + 3'd1;
    assign busy     = (state != IDLE);

    always_comb begin
        state_next    = state;
        target_next   = target_slot;
        prefer_b_next = prefer_b;
        iq_seen_next  = iq_seen;
        bound_next    = bound_cnt;
        fire_next     = 1'b0;
        missed_next   = 1'b0;
        overrun_next  = 1'b0;
        grant_a       = 1'b0;
        grant_b       = 1'b0;
        case (state)
            IDLE: begin
                // Grant is combinational so the requester sees it in its first IDLE cycle.
                if (!reset && (req_a || req_b)) begin
                    if (req_b && (!req_a || prefer_b)) begin
                        grant_b       = 1'b1;
                        target_next   = req_b_slot;
                        prefer_b_next = 1'b0;
                    end else begin
                        grant_a       = 1'b1;
                        target_next   = req_a_slot;
                        prefer_b_next = 1'b1;
                    end
                    state_next = PENDING;
                end
            end
            PENDING: begin
                if (boundary && (slot_inc == target_slot)) begin
                    if (is_armed) begin
                        fire_next    = 1'b1;
                        iq_seen_next = 1'b0;
                        bound_next   = '0;
                        state_next   = ACTIVE;
                    end else begin
                        missed_next = 1'b1;
                        state_next  = IDLE;
                    end
                end
            end
            ACTIVE: begin
                // Completion takes priority over a timeout landing in the same cycle.
                if (iq_seen && !iq_valid) begin
                    state_next = IDLE;
                end else if (boundary && (bound_cnt == BOUND_LAST)) begin
                    overrun_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    if (iq_valid) iq_seen_next = 1'b1;
                    if (boundary) bound_next = bound_cnt + TW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            sample_cnt  <= '0;
            slot_index  <= '0;
            target_slot <= '0;
            prefer_b    <= 1'b0;
            iq_seen     <= 1'b0;
            bound_cnt   <= '0;
            fire_burst  <= 1'b0;
            missed      <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_next;
            target_slot <= target_next;
            prefer_b    <= prefer_b_next;
            iq_seen     <= iq_seen_next;
            bound_cnt   <= bound_next;
            fire_burst  <= fire_next;
            missed      <= missed_next;
            overrun     <= overrun_next;
            if (sample_strobe)
                sample_cnt <= boundary ? '0 : sample_cnt + CW'(1);
            if (boundary)
                slot_index <= slot_inc;
        end
    end

`ifdef BURST_SCHED_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            fired_count  <= '0;
            missed_count <= '0;
        end else begin
            if (fire_burst && (fired_count != '1))
                fired_count <= fired_count + 16'd1;
            if (missed && (missed_count != '1))
                missed_count <= missed_count + 16'd1;
        end
    end
`else
    assign fired_count  = '0;
    assign missed_count = '0;
`endif

endmodule

// File: tb/tb_burst_scheduler.sv
// Self-checking bench for burst_scheduler: directed slot-timing scenarios plus randomized traffic against an event-level model.
module tb_burst_scheduler;

    localparam int SL = 4;
    localparam int NS = 8;
    localparam int TO = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sample_strobe = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic [2:0]  req_a_slot = '0, req_b_slot = '0;
    logic        is_armed = 1'b0, iq_valid = 1'b0;
    logic        grant_a, grant_b, fire_burst, missed, overrun, busy;
    logic [2:0]  slot_index;
    logic [15:0] fired_count, missed_count;

    burst_scheduler #(.SLOT_LEN(SL), .NUM_SLOTS(NS), .TIMEOUT_SLOTS(TO)) dut (
        .clock(clock), .reset(reset), .sample_strobe(sample_strobe),
        .req_a(req_a), .req_b(req_b), .req_a_slot(req_a_slot), .req_b_slot(req_b_slot),
        .grant_a(grant_a), .grant_b(grant_b), .is_armed(is_armed), .iq_valid(iq_valid),
        .fire_burst(fire_burst), .slot_index(slot_index), .missed(missed), .overrun(overrun),
        .busy(busy), .fired_count(fired_count), .missed_count(missed_count)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Event-level reference: elapsed samples, slot number, and the life of one outstanding burst.
    int m_cnt = 0, m_slot = 0, m_target = 0, m_bounds = 0, m_mode = 0; // mode: 0 none, 1 waiting for slot, 2 on air
    bit m_pref_b = 0, m_seen = 0, e_fire = 0, e_missed = 0, e_over = 0, model_ok = 0;
    int m_fired = 0, m_missed = 0;
    int nslot;
    bit bnd, mga, mgb;

    function automatic bit exp_ga();
        return !reset && m_mode == 0 && req_a && (!req_b || !m_pref_b);
    endfunction
    function automatic bit exp_gb();
        return !reset && m_mode == 0 && req_b && (!req_a || m_pref_b);
    endfunction
    function automatic int exp_fired();
`ifdef BURST_SCHED_STATS_EN
        return m_fired;
`else
        return 0;
`endif
    endfunction
    function automatic int exp_missed();
`ifdef BURST_SCHED_STATS_EN
        return m_missed;
`else
        return 0;
`endif
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_cnt = 0; m_slot = 0; m_target = 0; m_bounds = 0; m_mode = 0;
            m_pref_b = 0; m_seen = 0; e_fire = 0; e_missed = 0; e_over = 0;
            m_fired = 0; m_missed = 0; model_ok = 1;
        end else begin
            bnd   = sample_strobe && (m_cnt == SL - 1);
            nslot = bnd ? (m_slot + 1) % NS : m_slot;
            mga   = exp_ga();
            mgb   = exp_gb();
            if (e_fire && m_fired < 65535) m_fired++;
            if (e_missed && m_missed < 65535) m_missed++;
            e_fire = 0; e_missed = 0; e_over = 0;
            if (m_mode == 0) begin
                if (mga) begin m_target = req_a_slot; m_pref_b = 1; m_mode = 1; end
                else if (mgb) begin m_target = req_b_slot; m_pref_b = 0; m_mode = 1; end
            end else if (m_mode == 1) begin
                if (bnd && nslot == m_target) begin
                    if (is_armed) begin e_fire = 1; m_mode = 2; m_seen = 0; m_bounds = 0; end
                    else begin e_missed = 1; m_mode = 0; end
                end
            end else begin
                if (m_seen && !iq_valid) m_mode = 0;
                else if (bnd && m_bounds + 1 == TO) begin e_over = 1; m_mode = 0; end
                else begin
                    if (iq_valid) m_seen = 1;
                    if (bnd) m_bounds++;
                end
            end
            if (sample_strobe) m_cnt = (m_cnt + 1) % SL;
            m_slot = nslot;
        end
    end

    always @(negedge clock) begin
        if (model_ok) begin
            chk("grant_a", grant_a, exp_ga());
            chk("grant_b", grant_b, exp_gb());
            chk("fire_burst", fire_burst, e_fire);
            chk("missed", missed, e_missed);
            chk("overrun", overrun, e_over);
            chk("busy", busy, m_mode != 0);
            chk("slot_index", slot_index, m_slot);
            chk("fired_count", fired_count, exp_fired());
            chk("missed_count", missed_count, exp_missed());
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0; iq_valid = 1'b0;
        step();
        reset = 1'b0;
        cyc = 1;
    endtask

    int fire_cyc, over_cyc, miss_cyc, fire_n, miss_n, over_n;
    bit ga, gb;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        sample_strobe = 1'b1;
        step();

        // Slot-3 burst: grant in cycle 1, fire when slot 3 begins (cycle 13), done when iq_valid falls.
        is_armed = 1'b1;
        do_reset();
        req_a = 1'b1; req_a_slot = 3'd3;
        @(negedge clock);
        chk("s1_grant_a_cycle1", grant_a, 1);
        step();
        req_a = 1'b0;
        fire_cyc = -1;
        for (int i = 0; i < 40 && fire_cyc < 0; i++) begin
            @(negedge clock);
            if (fire_burst) fire_cyc = cyc;
            else step();
        end
        chk("s1_fire_cycle", fire_cyc, 13);
        chk("s1_fire_slot", slot_index, 3);
        step(); iq_valid = 1'b1;
        step();
        step(); iq_valid = 1'b0;
        @(negedge clock);
        chk("s1_busy_before_drop", busy, 1);
        step();
        @(negedge clock);
        chk("s1_busy_after_drop", busy, 0);

        // Round-robin from reset: A first, then B; both targets missed while disarmed.
        is_armed = 1'b0;
        do_reset();
        req_a = 1'b1; req_b = 1'b1; req_a_slot = 3'd2; req_b_slot = 3'd5;
        @(negedge clock);
        chk("s2_first_grant_a", grant_a, 1);
        chk("s2_first_grant_b", grant_b, 0);
        step();
        req_a = 1'b0; req_b = 1'b0;
        miss_cyc = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (missed) miss_cyc = cyc;
            if (!busy) break;
            step();
        end
        chk("s2_first_miss_cycle", miss_cyc, 9);
        step();
        req_a = 1'b1; req_b = 1'b1;
        @(negedge clock);
        chk("s2_second_grant_b", grant_b, 1);
        chk("s2_second_grant_a", grant_a, 0);
        step();
        req_a = 1'b0; req_b = 1'b0;
        miss_n = 0; fire_n = 0; miss_cyc = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (missed) begin miss_n++; miss_cyc = cyc; end
            if (fire_burst) fire_n++;
            if (!busy) break;
            step();
        end
        chk("s2_miss_count", miss_n, 1);
        chk("s2_miss_cycle", miss_cyc, 21);
        chk("s2_no_fire", fire_n, 0);
        chk("s2_idle", busy, 0);

        // Slot-7 burst with iq_valid stuck high: overrun on the second boundary after fire.
        is_armed = 1'b1;
        do_reset();
        req_a = 1'b1; req_a_slot = 3'd7;
        @(negedge clock);
        chk("s3_grant_a", grant_a, 1);
        step();
        req_a = 1'b0; iq_valid = 1'b1;
        fire_cyc = -1; over_cyc = -1; over_n = 0;
        for (int i = 0; i < 80 && over_cyc < 0; i++) begin
            @(negedge clock);
            if (fire_burst) fire_cyc = cyc;
            if (overrun) begin over_n++; over_cyc = cyc; end
            else step();
        end
        chk("s3_fire_cycle", fire_cyc, 29);
        chk("s3_overrun_cycle", over_cyc, 37);
        chk("s3_overrun_slot", slot_index, 1);
        chk("s3_overrun_idle", busy, 0);
        step(); iq_valid = 1'b0;

        // Reset while PENDING abandons the burst silently.
        do_reset();
        req_a = 1'b1; req_a_slot = 3'd3;
        step(); req_a = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("s4_busy", busy, 0);
        chk("s4_slot", slot_index, 0);
        chk("s4_fire", fire_burst, 0);
        chk("s4_missed", missed, 0);
        chk("s4_overrun", overrun, 0);
        chk("s4_fired_count", fired_count, 0);
        fire_n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            @(negedge clock);
            if (fire_burst || missed || overrun) fire_n++;
        end
        chk("s4_no_pulses", fire_n, 0);

        // Randomized traffic: strobe gaps, arming, iq_valid patterns, occasional reset.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            ga = grant_a; gb = grant_b;
            @(posedge clock);
            #1;
            cyc++;
            reset         = ($urandom_range(0, 249) == 0);
            sample_strobe = ($urandom_range(0, 3) != 0);
            is_armed      = ($urandom_range(0, 4) != 0);
            iq_valid      = ($urandom_range(0, 9) < ((i % 1000) < 500 ? 5 : 9));
            if (ga) req_a = 1'b0;
            else if (!req_a && $urandom_range(0, 7) == 0) begin
                req_a = 1'b1; req_a_slot = 3'($urandom_range(0, 7));
            end
            if (gb) req_b = 1'b0;
            else if (!req_b && $urandom_range(0, 7) == 0) begin
                req_b = 1'b1; req_b_slot = 3'($urandom_range(0, 7));
            end
        end
        reset = 1'b0; req_a = 1'b0; req_b = 1'b0;
        step();
        step();
        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
